instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode/control path (control unit, register file/ALU and branch logic). Owns the fetch program counter, issues word requests to a variable-latency instruction memory over a valid/ready request port, buffers in-order responses in a small FIFO, and presents `{PC, instr}` pairs to decode with a valid/ready handshake. A taken-branch redirect (`PCsrc`) reloads the fetch PC, flushes buffered instructions and discards stale in-flight responses.

---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to a variable-latency
// instruction memory and buffers in-order responses as {pc, instr} pairs for decode.
module instr_fetch #(
  parameter int unsigned                AddressWidth = 32,
  parameter int unsigned                DataWidth    = 32,
  parameter logic [AddressWidth-1:0]    ResetPc      = 32'hBFC0_0000,
  parameter int unsigned                FifoDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pc_src_i,
  input  logic [AddressWidth-1:0] branch_pc_i,
  input  logic [AddressWidth-1:0] imm_op_i,
  output logic                    imem_req_valid_o,
  input  logic                    imem_req_ready_i,
  output logic [AddressWidth-1:0] imem_req_addr_o,
  input  logic                    imem_resp_valid_i,
  input  logic [DataWidth-1:0]    imem_resp_data_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [DataWidth-1:0]    instr_o,
  output logic [AddressWidth-1:0] pc_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [AddressWidth-1:0] fpc_q, fpc_d;
  logic [AddressWidth-1:0] rpc_q, rpc_d;
  cnt_t                    outstanding_q, outstanding_d;
  cnt_t                    drop_q, drop_d;
  cnt_t                    count_q, count_d;
  ptr_t                    rd_ptr_q, rd_ptr_d;
  ptr_t                    wr_ptr_q, wr_ptr_d;
  logic [AddressWidth-1:0] pc_mem_q    [FifoDepth];
  logic [DataWidth-1:0]    instr_mem_q [FifoDepth];

  logic                    pop;
  logic                    push;
  logic                    accept;
  logic                    has_credit;
  logic [CntW:0]           used;
  logic [CntW:0]           limit;
  logic [AddressWidth-1:0] target;

  assign pop    = (count_q != '0) && instr_ready_i;
  assign accept = imem_req_valid_o && imem_req_ready_i;
  // A response is kept only when no redirect is happening and no stale responses remain.
  assign push   = imem_resp_valid_i && !pc_src_i && (drop_q == '0);
  assign target = (branch_pc_i + imm_op_i) & ~AddressWidth'(3);

  // Credit counts both buffered and in-flight words; a same-cycle pop frees one slot.
  assign used       = {1'b0, outstanding_q} + {1'b0, count_q};
  assign limit      = (CntW + 1)'(FifoDepth) + {{CntW{1'b0}}, pop};
  assign has_credit = used < limit;

  assign imem_req_valid_o = rst_ni && !pc_src_i && has_credit;
  assign imem_req_addr_o  = fpc_q;
  assign instr_valid_o    = count_q != '0;
  assign instr_o          = instr_mem_q[rd_ptr_q];
  assign pc_o             = pc_mem_q[rd_ptr_q];

  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (accept) begin
      fpc_d         = fpc_q + AddressWidth'(4);
      outstanding_d = outstanding_d + cnt_t'(1);
    end
    if (imem_resp_valid_i) begin
      outstanding_d = outstanding_d - cnt_t'(1);
    end

    if (pc_src_i) begin
      fpc_d    = target;
      rpc_d    = target;
      count_d  = '0;
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      wr_ptr_d = rd_ptr_d;
      // Everything still in flight is stale, except a word arriving now which is dropped here.
      drop_d   = outstanding_q - cnt_t'(imem_resp_valid_i);
    end else begin
      if (imem_resp_valid_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - cnt_t'(1);
        end else begin
          rpc_d = rpc_q + AddressWidth'(4);
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q         <= ResetPc;
      rpc_q         <= ResetPc;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        pc_mem_q[i]    <= ResetPc;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= rpc_q;
        instr_mem_q[wr_ptr_q] <= imem_resp_data_i;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   push |-> ((count_q != cnt_t'(FifoDepth)) || pop));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   imem_resp_valid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue-based memory and a queue-based fetch model
// predict every request and every {pc, instr} pair presented to decode.
module tb_instr_fetch;

  localparam int unsigned Aw      = 32;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'hBFC0_0000;

  logic          clk_i;
  logic          rst_ni;
  logic          pc_src_i;
  logic [Aw-1:0] branch_pc_i;
  logic [Aw-1:0] imm_op_i;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i;
  logic [Aw-1:0] imem_req_addr_o;
  logic          imem_resp_valid_i;
  logic [Dw-1:0] imem_resp_data_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [Dw-1:0] instr_o;
  logic [Aw-1:0] pc_o;

  instr_fetch #(
    .AddressWidth(Aw),
    .DataWidth   (Dw),
    .ResetPc     (ResetPc),
    .FifoDepth   (Depth)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .pc_src_i         (pc_src_i),
    .branch_pc_i      (branch_pc_i),
    .imm_op_i         (imm_op_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } entry_t;
  typedef struct packed { logic [31:0] addr; logic stale; } flight_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;

  entry_t      m_fifo[$];
  flight_t     m_flight[$];
  pend_t       mem_q[$];
  logic [31:0] m_fpc;
  logic        m_pop;
  logic        exp_req_valid;
  logic [97:0] exp_vec;
  int unsigned cyc;
  int unsigned mem_lat;
  int          compared;
  int          mismatched;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [97:0] observe();
    return {imem_req_valid_o, imem_req_valid_o ? imem_req_addr_o : 32'h0,
            instr_valid_o, instr_valid_o ? instr_o : 32'h0, instr_valid_o ? pc_o : 32'h0};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_flight.delete();
    mem_q.delete();
    m_fpc             = ResetPc;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
  endtask

  // Drive one cycle's inputs just after the rising edge and predict the outputs.
  task automatic setup(input logic rdy, input logic rq, input logic pcs,
                       input logic [31:0] bpc, input logic [31:0] imm);
    int credit;
    instr_ready_i    = rdy;
    imem_req_ready_i = rq;
    pc_src_i         = pcs;
    branch_pc_i      = bpc;
    imm_op_i         = imm;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
    end
    m_pop         = (m_fifo.size() > 0) && rdy;
    credit        = int'(Depth) - m_flight.size() - m_fifo.size() + (m_pop ? 1 : 0);
    exp_req_valid = !pcs && (credit > 0);
    exp_vec       = {exp_req_valid, exp_req_valid ? m_fpc : 32'h0, m_fifo.size() > 0,
                     m_fifo.size() > 0 ? m_fifo[0].data : 32'h0,
                     m_fifo.size() > 0 ? m_fifo[0].pc : 32'h0};
  endtask

  // Advance memory and model across the rising edge, then return to edge + 1.
  task automatic commit();
    flight_t f;
    if (imem_resp_valid_i) void'(mem_q.pop_front());
    if (imem_req_valid_o === 1'b1 && imem_req_ready_i)
      mem_q.push_back('{addr: imem_req_addr_o, due: cyc + mem_lat});
    if (m_pop) void'(m_fifo.pop_front());
    if (imem_resp_valid_i && m_flight.size() > 0) begin
      f = m_flight.pop_front();
      if (!f.stale && !pc_src_i) m_fifo.push_back('{pc: f.addr, data: imem_resp_data_i});
    end
    if (pc_src_i) begin
      m_fifo.delete();
      foreach (m_flight[i]) m_flight[i].stale = 1'b1;
      m_fpc = (branch_pc_i + imm_op_i) & 32'hFFFF_FFFC;
    end else if (exp_req_valid && imem_req_ready_i) begin
      m_flight.push_back('{addr: m_fpc, stale: 1'b0});
      m_fpc = m_fpc + 32'd4;
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    imem_resp_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    compared++;
    if ({imem_req_valid_o, instr_valid_o, instr_o, pc_o} !== {1'b0, 1'b0, 32'h0, ResetPc}) begin
      mismatched++;
      $display("FAIL reset_values got=%h required=%h",
               {imem_req_valid_o, instr_valid_o, instr_o, pc_o}, {1'b0, 1'b0, 32'h0, ResetPc});
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, ResetPc}) begin
      mismatched++;
      $display("FAIL first_request got=%h required=%h", {imem_req_valid_o, imem_req_addr_o},
               {1'b1, ResetPc});
    end
    commit();
  endtask

  task automatic test_stream();
    mem_lat = 1;
    for (int i = 0; i < 20; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL stream cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      if (i < 2) begin
        compared++;
        if ({instr_valid_o, instr_valid_o ? pc_o : 32'h0} !== {i == 1, i == 1 ? ResetPc : 32'h0})
        begin
          mismatched++;
          $display("FAIL first_delivery i=%0d valid=%b pc=%h", i, instr_valid_o, pc_o);
        end
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      setup(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL stall cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
    setup(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if ({imem_req_valid_o, instr_valid_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL full_stall got=%b required=01", {imem_req_valid_o, instr_valid_o});
    end
    commit();
    for (int i = 0; i < 10; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL drain cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_slow_mem();
    mem_lat = 3;
    for (int i = 0; i < 40; i++) begin
      setup(1'b1, i[0] == 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL slow_mem cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_redirect();
    bit found;
    bit seen;
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_flight.size() == 2) begin
        found = 1'b1;
      end else begin
        setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        compared++;
        if (observe() !== exp_vec) begin
          mismatched++;
          $display("FAIL pre_redirect cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
        end
        commit();
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL redirect_setup in_flight=%0d required=2", m_flight.size());
    end
    setup(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0);
    @(negedge clk_i);
    compared++;
    if (observe() !== exp_vec) begin
      mismatched++;
      $display("FAIL redirect_cycle got=%h required=%h", observe(), exp_vec);
    end
    commit();
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0000_00F0}) begin
      mismatched++;
      $display("FAIL redirect_target got=%h required=%h", {imem_req_valid_o, imem_req_addr_o},
               {1'b1, 32'h0000_00F0});
    end
    commit();
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL post_redirect cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      if (instr_valid_o === 1'b1 && !seen) begin
        seen = 1'b1;
        compared++;
        if (pc_o !== 32'h0000_00F0) begin
          mismatched++;
          $display("FAIL redirect_first_pc got=%h required=000000f0", pc_o);
        end
      end
      commit();
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL redirect_delivery got=none required=pc 000000f0");
    end
  endtask

  task automatic test_redirect_collide();
    bit done;
    mem_lat = 1;
    done    = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && m_fifo.size() > 0) begin
        done = 1'b1;
        setup(1'b1, 1'b1, 1'b1, $urandom & 32'h0000_FFFF, $urandom_range(0, 255));
      end else begin
        setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      end
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL collide cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL collide_setup got=no collision required=collision");
    end
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if (instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL collide_flush instr_valid=%b required=0", instr_valid_o);
    end
    commit();
    for (int i = 0; i < 10; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL post_collide cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      setup($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom, $urandom);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL random cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_reset_midstream();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      setup(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL fill cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    compared++;
    if ({imem_req_valid_o, instr_valid_o, instr_o, pc_o} !== {1'b0, 1'b0, 32'h0, ResetPc}) begin
      mismatched++;
      $display("FAIL async_reset got=%h required=%h",
               {imem_req_valid_o, instr_valid_o, instr_o, pc_o}, {1'b0, 1'b0, 32'h0, ResetPc});
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL restart cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
    setup(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_000C);
    @(negedge clk_i);
    compared++;
    if (observe() !== exp_vec) begin
      mismatched++;
      $display("FAIL wrap_redirect got=%h required=%h", observe(), exp_vec);
    end
    commit();
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      mismatched++;
      $display("FAIL wrap_target got=%h required=%h", {imem_req_valid_o, imem_req_addr_o},
               {1'b1, 32'hFFFF_FFFC});
    end
    commit();
    setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    compared++;
    if (imem_req_addr_o !== 32'h0) begin
      mismatched++;
      $display("FAIL wrap_next got=%h required=00000000", imem_req_addr_o);
    end
    commit();
    for (int i = 0; i < 8; i++) begin
      setup(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      compared++;
      if (observe() !== exp_vec) begin
        mismatched++;
        $display("FAIL post_wrap cyc=%0d got=%h required=%h", cyc, observe(), exp_vec);
      end
      commit();
    end
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    cyc               = 0;
    mem_lat           = 1;
    rst_ni            = 1'b0;
    pc_src_i          = 1'b0;
    branch_pc_i       = '0;
    imm_op_i          = '0;
    imem_req_ready_i  = 1'b0;
    instr_ready_i     = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_mem();
    test_redirect();
    test_redirect_collide();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
